// File: rtl/divider.sv
`default_nettype none
// ============================================================================
//  Module      : divider
//  Description : Iterative integer divider for the RV32M DIV, DIVU, REM and
//                REMU instructions. Radix-2 restoring division on operand
//                magnitudes (one quotient bit per cycle) followed by a sign
//                fixup and divide-by-zero override. Fixed 34-cycle latency
//                from the accepting edge, counting that cycle as the first.
//
//  Ports       : clk_i        rising-edge clock
//                rst_ni       synchronous active-low reset
//                start_i      request, sampled only in IDLE
//                operand_a_i  dividend
//                operand_b_i  divisor
//                func_i       00 DIV, 01 DIVU, 10 REM, 11 REMU
//                result_o     quotient or remainder (registered, held)
//                div_done_o   one-cycle completion pulse (registered)
//                busy_o       high while an operation is in flight
//
//  Revision    : 1.0  initial release
// ============================================================================
module divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic [1:0]      func_i,
    output logic [XLEN-1:0] result_o,
    output logic            div_done_o,
    output logic            busy_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CALC     = 2'd1;
    localparam logic [1:0] S_COMPLETE = 2'd2;

    localparam logic [1:0] c_func_div  = 2'b00;
    localparam logic [1:0] c_func_divu = 2'b01;
    localparam logic [1:0] c_func_rem  = 2'b10;

    // Counter value during the final iteration (32 iterations: 0..31).
    localparam logic [5:0] c_last_iter = 6'(XLEN - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [XLEN-1:0] r_rem;       // partial remainder
    logic [XLEN-1:0] r_quo;       // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0] r_divisor;   // divisor magnitude
    logic [XLEN-1:0] r_op_a;      // original dividend, returned by REM/REMU on div0
    logic [1:0]      r_func;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_div0;
    logic [5:0]      r_count;
    logic [XLEN-1:0] r_result;
    logic            r_done;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [1:0]      w_next_state;
    logic            w_load;
    logic            w_iter;
    logic            w_finish;
    logic            w_busy;
    logic            w_signed;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_trial;
    logic            w_trial_neg;
    logic [XLEN-1:0] w_final;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (start_i) w_next_state = S_CALC;
            S_CALC:     if (r_count == c_last_iter) w_next_state = S_COMPLETE;
            S_COMPLETE: w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / datapath controls
    // The done cycle is spent in IDLE, so busy also covers the pulse.
    // ------------------------------------------------------------------
    always_comb begin
        w_load   = 1'b0;
        w_iter   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE:     w_load   = start_i;
            S_CALC:     w_iter   = 1'b1;
            S_COMPLETE: w_finish = 1'b1;
            default:    ;
        endcase
        w_busy = (r_state != S_IDLE) || r_done;
    end

    // ------------------------------------------------------------------
    // Operand preparation: signed ops work on magnitudes
    // ------------------------------------------------------------------
    assign w_signed = ~func_i[0];
    assign w_sign_a = w_signed & operand_a_i[XLEN-1];
    assign w_sign_b = w_signed & operand_b_i[XLEN-1];
    assign w_mag_a  = w_sign_a ? (~operand_a_i + 1'b1) : operand_a_i;
    assign w_mag_b  = w_sign_b ? (~operand_b_i + 1'b1) : operand_b_i;

    // ------------------------------------------------------------------
    // One restoring step. The shifted remainder needs XLEN+1 bits; since
    // it is always below twice the divisor, bit XLEN of the trial
    // difference is a reliable "went negative" flag.
    // ------------------------------------------------------------------
    assign w_rem_sh    = {r_rem, r_quo[XLEN-1]};
    assign w_trial     = w_rem_sh - {1'b0, r_divisor};
    assign w_trial_neg = w_trial[XLEN];

    // ------------------------------------------------------------------
    // Sign fixup and divide-by-zero override. Signed overflow needs no
    // special case: |0x80000000| / 1 yields 0x80000000 with neg_q clear.
    // ------------------------------------------------------------------
    always_comb begin
        w_final = r_quo;
        case (r_func)
            c_func_div: begin
                if (r_div0)       w_final = '1;
                else if (r_neg_q) w_final = ~r_quo + 1'b1;
                else              w_final = r_quo;
            end
            c_func_divu: begin
                w_final = r_div0 ? '1 : r_quo;
            end
            c_func_rem: begin
                if (r_div0)       w_final = r_op_a;
                else if (r_neg_r) w_final = ~r_rem + 1'b1;
                else              w_final = r_rem;
            end
            default: begin
                w_final = r_div0 ? r_op_a : r_rem;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_op_a    <= '0;
            r_func    <= 2'b00;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_count   <= 6'd0;
            r_result  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_op_a    <= operand_a_i;
                r_func    <= func_i;
                r_quo     <= w_mag_a;
                r_divisor <= w_mag_b;
                r_neg_q   <= w_sign_a ^ w_sign_b;
                r_neg_r   <= w_sign_a;
                r_div0    <= (operand_b_i == '0);
                r_rem     <= '0;
                r_count   <= 6'd0;
            end else if (w_iter) begin
                r_rem   <= w_trial_neg ? w_rem_sh[XLEN-1:0] : w_trial[XLEN-1:0];
                r_quo   <= {r_quo[XLEN-2:0], ~w_trial_neg};
                r_count <= r_count + 6'd1;
            end else if (w_finish) begin
                r_result <= w_final;
                r_done   <= 1'b1;
            end
        end
    end

    assign result_o   = r_result;
    assign div_done_o = r_done;
    assign busy_o     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider
//  Description : Scoreboard bench for the divider. Each accepted request
//                pushes the reference result and its accepting edge number;
//                a negedge monitor pops and compares on every div_done_o,
//                including the start-to-done edge distance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_divider;

    localparam int c_done_dist = 33;   // accept edge k -> done pulse from edge k+33

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic [1:0]  func_i;
    logic [31:0] result_o;
    logic        div_done_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [31:0] res;
        int unsigned start_cyc;
    } exp_t;

    exp_t exp_q[$];

    divider #(.XLEN(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .func_i      (func_i),
        .result_o    (result_o),
        .div_done_o  (div_done_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain wide arithmetic with the RV32M special cases.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] f);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Wait (bounded) for the divider to be idle, then issue one request.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
        exp_t e;
        int n;
        n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'(busy_o), 32'd0);
        operand_a_i = a;
        operand_b_i = b;
        func_i      = f;
        start_i     = 1'b1;
        e.res       = ref_div(a, b, f);
        e.start_cyc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Monitor: every completion must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_ni && div_done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", result_o, e.res);
                check("latency", cyc - e.start_cyc, c_done_dist);
            end
        end
    end

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        operand_a_i = '0;
        operand_b_i = '0;
        func_i      = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_result", result_o, 32'd0);
        check("reset_done", 32'(div_done_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(32'hFFFF_FFEC, 32'd3, 2'b00);          // -20/3 -> -6
        issue(32'hFFFF_FFEC, 32'd3, 2'b10);          // -20%3 -> -2
        issue(32'hFFFF_FFFF, 32'd2, 2'b01);          // DIVU
        issue(32'hFFFF_FFFF, 32'd2, 2'b11);          // REMU
        issue(32'hFFFF_FFFF, 32'd2, 2'b00);          // -1/2 -> 0
        issue(32'd7, 32'd0, 2'b00);                  // div0
        issue(32'd7, 32'd0, 2'b11);
        issue(32'hFFFF_FFF9, 32'd0, 2'b10);
        issue(32'hFFFF_FFF9, 32'd0, 2'b01);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b00);  // overflow
        issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b10);
        issue(32'd20, 32'hFFFF_FFFD, 2'b10);         // 20 % -3 -> 2

        // Start while busy is ignored
        issue(32'd1000, 32'd7, 2'b00);
        repeat (5) @(negedge clk);
        operand_a_i = 32'd55;
        operand_b_i = 32'd5;
        func_i      = 2'b11;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;

        // func_i changes mid-operation
        issue(32'hFFFF_FF00, 32'd9, 2'b10);
        repeat (4) @(negedge clk);
        func_i = 2'b01;

        // start_i held high: three back-to-back operations
        begin
            int n;
            exp_t e;
            n = 0;
            while (busy_o && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) check("idle_timeout", 32'(busy_o), 32'd0);
            operand_a_i = 32'hDEAD_BEEF;
            operand_b_i = 32'h0000_1234;
            func_i      = 2'b00;
            start_i     = 1'b1;
            e.res = ref_div(32'hDEAD_BEEF, 32'h0000_1234, 2'b00);
            for (int i = 0; i < 3; i++) begin
                e.start_cyc = cyc + 1 + 34 * i;
                exp_q.push_back(e);
            end
            repeat (69) @(negedge clk);
            start_i = 1'b0;
        end

        // Reset at iteration 10 aborts the operation
        issue(32'd1000, 32'd3, 2'b01);
        repeat (9) @(negedge clk);
        void'(exp_q.pop_back());
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_result", result_o, 32'd0);
        check("abort_done", 32'(div_done_o), 32'd0);
        repeat (40) @(negedge clk);
        issue(32'd100, 32'd7, 2'b01);                // -> 14

        // Randomized operands with biased corner values
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                4: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            issue(a, b, 2'($urandom_range(0, 3)));
        end

        // Drain outstanding expectations
        begin
            int n;
            n = 0;
            while (exp_q.size() > 0 && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        end
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divider.md
Name: divider

Overview:
- Iterative 32-bit integer divider for the RV32M DIV, DIVU, REM and REMU instructions.
- Companion to the execute-stage multiplier; uses the same start/done handshake and the same 2-bit function select style.
- Radix-2 restoring division on operand magnitudes, followed by sign fixup.
- Fixed latency, one result per operation.

Parameters:
XLEN, 32, operand/result width (only 32 is supported)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  synchronous active-low reset
start_i  input  1  request; sampled only in IDLE
operand_a_i  input  32  dividend
operand_b_i  input  32  divisor
func_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
result_o  output  32  quotient or remainder, registered
div_done_o  output  1  one-cycle completion pulse, registered
busy_o  output  1  high while an operation is in flight

Behaviour:
Reset:
- rst_ni low at a rising edge: state=IDLE; result_o=0; div_done_o=0; busy_o=0; all internal registers 0.
- Reset mid-operation aborts the operation; no div_done_o pulse follows.

States:
- IDLE:
  - start_i=1 at edge k latches operand_a_i, operand_b_i and func_i. func_i is not re-read afterwards.
  - Signed ops (func_i[0]=0): a negative operand is replaced by its two's-complement magnitude.
  - Records neg_q = sign_a XOR sign_b, and neg_r = sign_a.
  - Records div0 = (operand_b_i==0).
  - Clears the 32-bit remainder accumulator and the 6-bit iteration counter, then goes to CALC.
- CALC: one iteration per cycle for exactly 32 cycles (edges k+1..k+32). Each iteration:
  - Shift {rem, dividend} left 1.
  - Compute trial = rem_shifted − divisor using a 33-bit subtract.
  - If trial is non-negative: rem = trial and the quotient LSB = 1. Otherwise keep the shifted rem and the quotient LSB = 0.
  - After count reaches 32, go to COMPLETE.
- COMPLETE (edge k+33):
  - Computes the final value and registers it into result_o.
  - Sets div_done_o=1 for exactly one cycle, then returns to IDLE.

Sign fixup and special cases (applied in COMPLETE):
- DIV: q = neg_q ? −quotient : quotient.
- REM: r = neg_r ? −remainder : remainder. The remainder takes the sign of the dividend.
- DIVU / REMU: raw quotient / remainder.
- Divide by zero (div0), overriding the above:
  - DIV and DIVU return 0xFFFFFFFF.
  - REM and REMU return the original, un-negated operand_a.
- Signed overflow (0x80000000 / 0xFFFFFFFF):
  - DIV returns 0x80000000 and REM returns 0.
  - This falls out of the magnitude path. A dedicated override is permitted but must give identical results.

Timing and handshake:
- Latency is fixed at 34 cycles for all inputs, including div0 and overflow.
- div_done_o is high in the cycle following edge k+33.
- result_o is valid in the same cycle as div_done_o. It holds that value until the next completion or reset.
- busy_o is high from the cycle after edge k through the div_done_o cycle, and low in IDLE.
- start_i while busy_o=1 is ignored; no queuing.
- start_i held high continuously: a new operation begins at the first edge in IDLE. That edge is the one immediately after the done cycle, which is back-to-back with a 1-cycle gap.
- All arithmetic wraps modulo 2^32, except the 33-bit trial subtract.

Test Plan:
1. Signed division with negative dividend:
   - DIV a=0xFFFFFFEC (−20), b=3 → result_o=0xFFFFFFFA (−6).
   - REM with the same operands → 0xFFFFFFFE (−2).
   - Each completes with div_done_o exactly 34 cycles after start.
2. Unsigned division and remainder:
   - DIVU a=0xFFFFFFFF, b=2 → 0x7FFFFFFF.
   - REMU with the same operands → 1.
   - DIV with the same operands → 0 (−1/2 truncates to 0).
3. Divide by zero:
   - DIV a=7, b=0 → 0xFFFFFFFF.
   - REMU a=7, b=0 → 7.
   - REM a=0xFFFFFFF9, b=0 → 0xFFFFFFF9.
   - Latency is still 34 cycles.
4. Signed overflow:
   - DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000.
   - REM with the same operands → 0.
5. Handshake:
   - A start_i pulse with different operands while busy_o=1 is ignored, and the first result is unaffected.
   - func_i changing mid-operation does not alter the result.
   - start_i held high gives back-to-back operations with exactly one div_done_o pulse each.
6. Reset:
   - rst_ni low for 1 cycle at iteration 10 → next cycle busy_o=0, result_o=0, and no div_done_o pulse.
   - A new DIVU 100/7 afterwards → 14.
